led_spi_pixel_master: RTL

- SPI mode-0 master that writes one pixel per 32-bit frame to the LED matrix driver's SPI slave port.
- Sits on the host/controller FPGA side, or inside a test harness in front of the matrix board.
- Takes address + 24-bit RGB over a valid/ready handshake.
- Serialises frame {2'b00, addr[5:0], R[7:0], G[7:0], B[7:0]} MSB first, framed by cs.

---
 rtl/led_spi_pixel_master_pkg.sv | 28 ++
 rtl/led_spi_sclk_timer.sv | 22 ++
 rtl/led_spi_pixel_master.sv | 94 +++++++++
 3 files changed

// File: rtl/led_spi_pixel_master_pkg.sv
// led_spi_pixel_master_pkg: shared frame layout, field positions and FSM encoding for the LED SPI pixel link.
// Contents: FRAME_BITS/ADDR_W/RGB_W widths, ADDR_MSB/ADDR_LSB/RGB_MSB field positions,
// state_t FSM encoding and make_frame() which packs {2'b00, addr, rgb} into one frame word.
package led_spi_pixel_master_pkg;
   localparam int FRAME_BITS = 32;
   localparam int ADDR_W     = 6;
   localparam int RGB_W      = 24;
   localparam int ADDR_MSB   = 29;
   localparam int ADDR_LSB   = 24;
   localparam int RGB_MSB    = 23;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT_HI,
      ST_SHIFT_LO,
      ST_GAP
   } state_t;

   function automatic logic [FRAME_BITS-1:0] make_frame(input logic [ADDR_W-1:0] addr,
                                                        input logic [RGB_W-1:0] rgb);
      logic [FRAME_BITS-1:0] f;
      f = '0;
      f[ADDR_MSB:ADDR_LSB] = addr;
      f[RGB_MSB:0] = rgb;
      return f;
   endfunction
endpackage

// File: rtl/led_spi_sclk_timer.sv
// led_spi_sclk_timer: down-counter timing each FSM phase; reloads on load, flags expired at zero.
// Ports: clk, rst (sync, active-high), load (reload strobe), load_val (phase length minus one),
// expired (counter has reached zero, i.e. the current phase ends this cycle).
module led_spi_sclk_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - W'(1);
   end

   assign expired = cnt == '0;
endmodule

// File: rtl/led_spi_pixel_master.sv
// led_spi_pixel_master: SPI mode-0 master sending one 32-bit pixel frame {2'b00, addr, R, G, B} MSB first.
// Ports: clk, rst (sync, active-high); in_valid/in_ready handshake with in_addr (pixel 0..63) and in_rgb ({R,G,B});
// sclk (idle low), mosi (changes while sclk low), cs (active-low frame select);
// busy (accept until back in IDLE), done (one-cycle pulse when the frame completes).
module led_spi_pixel_master
   import led_spi_pixel_master_pkg::*;
#(
   parameter int CLK_DIV = 8,
   parameter int CS_GAP  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [RGB_W-1:0]  in_rgb,
   output logic              sclk,
   output logic              mosi,
   output logic              cs,
   output logic              busy,
   output logic              done
);
   localparam int CW = $clog2((CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP) + 1);

   state_t                state, next_state;
   logic [FRAME_BITS-1:0] sr, frame;
   logic [4:0]            bit_cnt;
   logic                  last_bit;
   logic                  accept, expired, load;
   logic [CW-1:0]         load_val;

   assign accept = in_valid && in_ready;
   assign frame  = make_frame(in_addr, in_rgb);

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:     next_state = accept ? ST_SETUP : ST_IDLE;
         ST_SETUP:    next_state = expired ? ST_SHIFT_HI : ST_SETUP;
         ST_SHIFT_HI: next_state = expired ? ST_SHIFT_LO : ST_SHIFT_HI;
         ST_SHIFT_LO: next_state = expired ? (last_bit ? ST_GAP : ST_SHIFT_HI) : ST_SHIFT_LO;
         ST_GAP:      next_state = expired ? ST_IDLE : ST_GAP;
         default:     next_state = ST_IDLE;
      endcase
   end

   // The IDLE cycle that follows GAP also keeps cs high, so GAP itself runs one
   // cycle short: cs-high between back-to-back frames is then exactly CS_GAP.
   assign load     = next_state != state;
   assign load_val = CW'(next_state == ST_GAP ? CS_GAP - 2 : CLK_DIV - 1);

   led_spi_sclk_timer #(.W(CW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .expired  (expired)
   );

   // Outputs are registered from next_state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         sr       <= '0;
         bit_cnt  <= '0;
         last_bit <= 1'b0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cs       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         in_ready <= 1'b0;
      end else begin
         state    <= next_state;
         sclk     <= next_state == ST_SHIFT_HI;
         cs       <= next_state == ST_IDLE || next_state == ST_GAP;
         busy     <= next_state != ST_IDLE;
         done     <= next_state == ST_GAP && state != ST_GAP;
         in_ready <= next_state == ST_IDLE;
         if (accept) begin
            sr       <= frame;
            mosi     <= frame[FRAME_BITS-1];
            bit_cnt  <= 5'd31;
            last_bit <= 1'b0;
         end else if (state == ST_SHIFT_HI && expired) begin
            // Leaving the high phase: present the next bit, or 0 once bit0 has been sampled.
            sr       <= sr << 1;
            mosi     <= (bit_cnt != 5'd0) && sr[FRAME_BITS-2];
            bit_cnt  <= bit_cnt - 5'd1;
            last_bit <= bit_cnt == 5'd0;
         end
      end
   end
endmodule
